object_fetch: RTL and testbench

OBJECT_FETCH -- requirements
Module: object_fetch

---
 rtl/object_fetch.sv | 220 ++++++++++++++++++++++
 tb/tb_object_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/object_fetch.sv
// -----------------------------------------------------------------------------
// object_fetch
//
// Captures a scene description from the object host bus on frame_start and
// streams it to a downstream consumer as two records over a valid/ready
// handshake: first the view record, then the sphere record. A copy of the
// previous frame's capture is kept so the block can report whether the scene
// changed. With SKIP_CLEAN=1, an unchanged frame emits no records and goes
// straight to its frame_done pulse.
//
// Ports
//   clk          in   1    sole clock, rising edge
//   rst          in   1    asynchronous, active-high reset
//   in_bus       in   128  object bus (bits [127:116] are not used)
//                          [27:0]    view point     [58:28]  view normal
//                          [66:59]   view dist      [67]     light_en
//                          [95:68]   sphere centre  [103:96] sphere radius
//                          [115:104] sphere colour
//   frame_start  in   1    single-cycle request to capture and stream a frame
//   obj_ready    in   1    consumer accepts the current record
//   obj_valid    out  1    record on obj_* is valid
//   obj_type     out  1    0 = view record, 1 = sphere record
//   obj_point    out  28   view point / sphere centre
//   obj_vec      out  31   view normal (zero for sphere)
//   obj_dist     out  8    view dist / sphere radius
//   obj_flag     out  1    light_en (zero for sphere)
//   obj_color    out  12   sphere colour (zero for view)
//   scene_dirty  out  1    last capture differed from the one before it
//   busy         out  1    high whenever the FSM is not idle
//   frame_done   out  1    one-cycle pulse at the end of each frame
//   overrun      out  1    sticky: frame_start seen while busy
// -----------------------------------------------------------------------------
module object_fetch #(
    parameter bit SKIP_CLEAN = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_bus,
    input  logic         frame_start,
    input  logic         obj_ready,
    output logic         obj_valid,
    output logic         obj_type,
    output logic [27:0]  obj_point,
    output logic [30:0]  obj_vec,
    output logic [7:0]   obj_dist,
    output logic         obj_flag,
    output logic [11:0]  obj_color,
    output logic         scene_dirty,
    output logic         busy,
    output logic         frame_done,
    output logic         overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_VIEW,
        S_SEND_SPHERE,
        S_DONE
    } state_t;

    localparam int SNAP_W = 116;

    state_t              state_q,   state_d;
    logic [SNAP_W-1:0]   snap_q,    snap_d;
    logic [SNAP_W-1:0]   prev_q,    prev_d;
    logic                first_q,   first_d;
    logic                dirty_q,   dirty_d;
    logic                overrun_q, overrun_d;

    // Registered record outputs
    logic                valid_q,   valid_d;
    logic                type_q,    type_d;
    logic [27:0]         point_q,   point_d;
    logic [30:0]         vec_q,     vec_d;
    logic [7:0]          dist_q,    dist_d;
    logic                flag_q,    flag_d;
    logic [11:0]         color_q,   color_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;

    logic                dirty_now;

    // Upper bus bits carry nothing for this block.
    logic                unused_bus_hi;
    assign unused_bus_hi = ^in_bus[127:SNAP_W];

    // The very first frame after reset is always reported dirty.
    assign dirty_now = (in_bus[SNAP_W-1:0] != prev_q) || first_q;

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        prev_d    = prev_q;
        first_d   = first_q;
        dirty_d   = dirty_q;
        overrun_d = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    snap_d  = in_bus[SNAP_W-1:0];
                    prev_d  = in_bus[SNAP_W-1:0];
                    first_d = 1'b0;
                    dirty_d = dirty_now;
                    if (SKIP_CLEAN && !dirty_now) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEND_VIEW;
                    end
                end
            end
            S_SEND_VIEW: begin
                if (obj_ready) begin
                    state_d = S_SEND_SPHERE;
                end
            end
            S_SEND_SPHERE: begin
                if (obj_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A request arriving outside IDLE (including DONE) is dropped and flagged.
        if (frame_start && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        // Outputs are decoded from the next state and next snapshot so they
        // come straight out of flops and line up with the state register.
        valid_d = 1'b0;
        type_d  = 1'b0;
        point_d = '0;
        vec_d   = '0;
        dist_d  = '0;
        flag_d  = 1'b0;
        color_d = '0;
        done_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);

        case (state_d)
            S_SEND_VIEW: begin
                valid_d = 1'b1;
                type_d  = 1'b0;
                point_d = snap_d[27:0];
                vec_d   = snap_d[58:28];
                dist_d  = snap_d[66:59];
                flag_d  = snap_d[67];
            end
            S_SEND_SPHERE: begin
                valid_d = 1'b1;
                type_d  = 1'b1;
                point_d = snap_d[95:68];
                dist_d  = snap_d[103:96];
                color_d = snap_d[115:104];
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            prev_q    <= '0;
            first_q   <= 1'b1;
            dirty_q   <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            type_q    <= 1'b0;
            point_q   <= '0;
            vec_q     <= '0;
            dist_q    <= '0;
            flag_q    <= 1'b0;
            color_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            prev_q    <= prev_d;
            first_q   <= first_d;
            dirty_q   <= dirty_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            type_q    <= type_d;
            point_q   <= point_d;
            vec_q     <= vec_d;
            dist_q    <= dist_d;
            flag_q    <= flag_d;
            color_q   <= color_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign obj_valid   = valid_q;
    assign obj_type    = type_q;
    assign obj_point   = point_q;
    assign obj_vec     = vec_q;
    assign obj_dist    = dist_q;
    assign obj_flag    = flag_q;
    assign obj_color   = color_q;
    assign scene_dirty = dirty_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_object_fetch.sv
module tb_object_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_bus;
    logic         frame_start;
    logic         obj_ready;
    logic         obj_valid;
    logic         obj_type;
    logic [27:0]  obj_point;
    logic [30:0]  obj_vec;
    logic [7:0]   obj_dist;
    logic         obj_flag;
    logic [11:0]  obj_color;
    logic         scene_dirty;
    logic         busy;
    logic         frame_done;
    logic         overrun;

    always #5 clk = ~clk;

    object_fetch #(.SKIP_CLEAN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_bus      (in_bus),
        .frame_start (frame_start),
        .obj_ready   (obj_ready),
        .obj_valid   (obj_valid),
        .obj_type    (obj_type),
        .obj_point   (obj_point),
        .obj_vec     (obj_vec),
        .obj_dist    (obj_dist),
        .obj_flag    (obj_flag),
        .obj_color   (obj_color),
        .scene_dirty (scene_dirty),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    typedef logic [80:0] rec_t;

    logic [80:0] cur_rec;
    logic [85:0] all_out;
    assign cur_rec = {obj_type, obj_point, obj_vec, obj_dist, obj_flag, obj_color};
    assign all_out = {cur_rec, scene_dirty, busy, frame_done, overrun};

    rec_t exp_rec[$];
    bit   exp_dirty[$];
    int   n_vec = 0;
    int   n_err = 0;
    rec_t mon_rec;
    bit   mon_dirty;

    function automatic rec_t mk(input bit t, input logic [27:0] p, input logic [30:0] v,
                                input logic [7:0] d, input bit f, input logic [11:0] c);
        return {t, p, v, d, f, c};
    endfunction

    function automatic logic [127:0] mkbus(input logic [27:0] vp, input logic [30:0] vn,
                                           input logic [7:0] vd, input bit le,
                                           input logic [27:0] sc, input logic [7:0] sr,
                                           input logic [11:0] col, input logic [11:0] hi);
        return {hi, col, sr, sc, le, vd, vn, vp};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents output.
    initial begin
        forever begin
            @(negedge clk);
            if (obj_valid && obj_ready) begin
                if (exp_rec.size() == 0) begin
                    chk("unexpected_record", 128'(obj_valid), 128'd0);
                end else begin
                    mon_rec = exp_rec.pop_front();
                    chk("record", 128'(cur_rec), 128'(mon_rec));
                end
            end else if (!obj_valid) begin
                chk("fields_zero_when_invalid", 128'(cur_rec), 128'd0);
            end
            if (frame_done) begin
                if (exp_dirty.size() == 0) begin
                    chk("unexpected_frame_done", 128'(frame_done), 128'd0);
                end else begin
                    mon_dirty = exp_dirty.pop_front();
                    chk("scene_dirty_at_done", 128'(scene_dirty), 128'(mon_dirty));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called one delta past a posedge in IDLE; returns one delta past the capture edge.
    task automatic start_frame(input logic [127:0] b);
        in_bus      = b;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    // Waits for frame_done (bounded), reports edges waited, then steps into IDLE.
    task automatic wait_done(output int n);
        n = 0;
        while (!frame_done && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("frame_done_seen", 128'(frame_done), 128'd1);
        @(posedge clk);
        #1;
        chk("idle_after_done", 128'({busy, frame_done}), 128'd0);
    endtask

    logic [127:0] bus_a, bus_a4, bus_a5, bus_b, bus_c, bus_d;
    rec_t         view_a;
    int           n;

    initial begin
        bus_a  = mkbus(28'h1234567, 31'h1ABCDEF0, 8'h5A, 1'b1, 28'h0FEDCBA, 8'h33, 12'hC3F, 12'h000);
        bus_a4 = mkbus(28'h1234567, 31'h1ABCDEF0, 8'h5A, 1'b1, 28'h0FEDCBA, 8'h33, 12'hC3F, 12'h001);
        bus_a5 = mkbus(28'h1234567, 31'h1ABCDEF0, 8'h5A, 1'b1, 28'h0FEDCBA, 8'h23, 12'hC3F, 12'h001);
        bus_b  = mkbus(28'h0ABCDEF, 31'h00000123, 8'h10, 1'b0, 28'h0000042, 8'h07, 12'h00F, 12'h000);
        bus_c  = mkbus(28'h1111111, 31'h00000123, 8'h10, 1'b0, 28'h0000042, 8'h07, 12'h00F, 12'h000);
        bus_d  = mkbus(28'h0000F0F, 31'h7FFFFFFF, 8'hFF, 1'b1, 28'hFFFFFFF, 8'h80, 12'hFFF, 12'hABC);
        view_a = mk(1'b0, 28'h1234567, 31'h1ABCDEF0, 8'h5A, 1'b1, 12'h000);

        rst = 1'b1; frame_start = 1'b0; obj_ready = 1'b0; in_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 128'(all_out), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First frame: point=1, everything else zero, consumer always ready.
        obj_ready = 1'b1;
        exp_rec.push_back(mk(1'b0, 28'h1, 31'h0, 8'h0, 1'b0, 12'h0));
        exp_rec.push_back(mk(1'b1, 28'h0, 31'h0, 8'h0, 1'b0, 12'h0));
        exp_dirty.push_back(1'b1);
        start_frame(mkbus(28'h1, 31'h0, 8'h0, 1'b0, 28'h0, 8'h0, 12'h0, 12'h0));
        chk("t1_valid_after_capture", 128'({obj_valid, busy}), 128'd3);
        wait_done(n);
        chk("t1_done_latency", 128'(n), 128'd2);

        // Stall five cycles in SEND_VIEW while the bus toggles.
        obj_ready = 1'b0;
        exp_rec.push_back(view_a);
        exp_rec.push_back(mk(1'b1, 28'h0FEDCBA, 31'h0, 8'h33, 1'b0, 12'hC3F));
        exp_dirty.push_back(1'b1);
        start_frame(bus_a);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 128'(obj_valid), 128'd1);
            chk("t2_hold_record", 128'(cur_rec), 128'(view_a));
            in_bus = ~in_bus;
            @(posedge clk);
            #1;
        end
        chk("t2_hold_record_end", 128'(cur_rec), 128'(view_a));
        obj_ready = 1'b1;
        wait_done(n);
        chk("t2_done_latency", 128'(n), 128'd2);

        // Identical frame with SKIP_CLEAN: no records, done right after capture.
        exp_dirty.push_back(1'b0);
        start_frame(bus_a);
        chk("t3_done_now", 128'({frame_done, obj_valid, scene_dirty}), 128'b100);
        wait_done(n);
        chk("t3_done_latency", 128'(n), 128'd0);

        // Only bit 116 differs: still clean.
        exp_dirty.push_back(1'b0);
        start_frame(bus_a4);
        chk("t4_bit116_clean", 128'({scene_dirty, obj_valid}), 128'd0);
        wait_done(n);

        // Radius bit 100 flipped: dirty, new radius 0x23 on the sphere record.
        exp_rec.push_back(view_a);
        exp_rec.push_back(mk(1'b1, 28'h0FEDCBA, 31'h0, 8'h23, 1'b0, 12'hC3F));
        exp_dirty.push_back(1'b1);
        start_frame(bus_a5);
        chk("t5_radius_dirty", 128'(scene_dirty), 128'd1);
        wait_done(n);

        // frame_start during SEND_SPHERE: overrun, no capture, frame completes.
        exp_rec.push_back(mk(1'b0, 28'h0ABCDEF, 31'h123, 8'h10, 1'b0, 12'h0));
        exp_rec.push_back(mk(1'b1, 28'h0000042, 31'h0, 8'h07, 1'b0, 12'h00F));
        exp_dirty.push_back(1'b1);
        chk("t6_overrun_before", 128'(overrun), 128'd0);
        start_frame(bus_b);
        @(posedge clk);
        #1;
        obj_ready   = 1'b0;
        in_bus      = bus_c;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        chk("t6_overrun_set", 128'(overrun), 128'd1);
        chk("t6_still_sphere", 128'({obj_valid, obj_type, obj_point}), 128'({1'b1, 1'b1, 28'h0000042}));
        obj_ready = 1'b1;
        wait_done(n);
        chk("t6_overrun_sticky", 128'(overrun), 128'd1);
        // bus_b again must be clean, proving bus_c was never captured.
        exp_dirty.push_back(1'b0);
        start_frame(bus_b);
        chk("t6_no_capture", 128'(scene_dirty), 128'd0);
        wait_done(n);

        // Reset while in SEND_SPHERE.
        exp_rec.push_back(mk(1'b0, 28'h0000F0F, 31'h7FFFFFFF, 8'hFF, 1'b1, 12'h0));
        start_frame(bus_d);
        @(posedge clk);
        #1;
        obj_ready = 1'b0;
        chk("t7_in_sphere", 128'({obj_valid, obj_type}), 128'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_reset_outputs", 128'(all_out), 128'd0);
        @(posedge clk);
        #1;
        chk("t7_no_done", 128'({frame_done, busy}), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        obj_ready = 1'b1;
        exp_rec.push_back(mk(1'b0, 28'h0000F0F, 31'h7FFFFFFF, 8'hFF, 1'b1, 12'h0));
        exp_rec.push_back(mk(1'b1, 28'hFFFFFFF, 31'h0, 8'h80, 1'b0, 12'hFFF));
        exp_dirty.push_back(1'b1);
        start_frame(bus_d);
        chk("t7_dirty_after_reset", 128'(scene_dirty), 128'd1);
        wait_done(n);

        repeat (2) @(posedge clk);
        #1;
        chk("record_queue_drained", 128'(exp_rec.size()), 128'd0);
        chk("dirty_queue_drained", 128'(exp_dirty.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
